cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares a limited number of common-data-bus broadcast lanes among the four result producers: FXU0, FXU1, LSU and the branch unit.
- Each producer pushes results into a small private result buffer.
- Each cycle the arbiter selects up to NUM_LANES buffer heads in rotating-priority order and drives them onto registered CDB lanes.
- The ROB and all reservation stations snoop these lanes.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 = FXU0, 1 = FXU1, 2 = LSU, 3 = branch.
- NUM_LANES, 2, CDB broadcast lanes; legal range 1..NUM_REQ.
- BUF_DEPTH, 2, entries per requester result buffer; power of two, ≥ 1.
- ROB_IDX_W, 4, ROB index width.
- DATA_W, 16, result value width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush; clears all buffers and lanes.
- rob_head  input  ROB_IDX_W  current ROB head; used only with the optional feature.
- req_valid  input  NUM_REQ  per-requester result valid.
- req_rob_idx  input  NUM_REQ*ROB_IDX_W  flat; requester r occupies bits [r*ROB_IDX_W +: ROB_IDX_W].
- req_value  input  NUM_REQ*DATA_W  flat; requester r occupies bits [r*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  buffer r can accept a result.
- cdb_valid  output  NUM_LANES  lane broadcast valid.
- indices  output  NUM_LANES*ROB_IDX_W  flat ROB index per lane.
- new_values  output  NUM_LANES*DATA_W  flat value per lane.
- stall_any  output  1  at least one buffer is non-empty but was not granted this cycle.

Behaviour:
- Reset (async, rst=1):
  - All buffers empty; all pointers and counts 0; round-robin pointer rr_ptr=0.
  - cdb_valid=0, indices=0, new_values=0, stall_any=0.
  - req_ready=1 for every requester as soon as rst deasserts.
- Push:
  - Requester r transfers on a rising edge when req_valid[r] & req_ready[r].
  - req_ready[r] = (count[r] != BUF_DEPTH), from registered count only; there is no combinational path from pop to ready.
  - A full buffer stays not-ready even in a cycle it pops.
- Arbitration (combinational, over current buffer heads):
  - Candidates are the requesters with a non-empty buffer.
  - Scan order starts at rr_ptr: rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first NUM_LANES candidates are granted; the k-th granted maps to lane k (lane 0 first).
- Grant at rising edge:
  - Granted heads are popped; lane registers load {1, rob_idx, value}.
  - Lanes with no grant load cdb_valid=0, indices=0, new_values=0.
  - rr_ptr advances to (last granted requester + 1) mod NUM_REQ; it is unchanged if nothing was granted.
- Latency:
  - Result pushed at edge k is earliest on the CDB after edge k+1, i.e. 2 edges from handshake.
  - Each lane is valid for exactly one cycle per result.
- Ordering:
  - Results from one requester are broadcast in push order.
  - No ordering guarantee across requesters.
- Simultaneous push and pop on the same buffer: both take effect; count unchanged.
- stall_any: registered; set at an edge if the number of candidates exceeded NUM_LANES in the preceding cycle.
- flush:
  - Synchronous, takes priority over push and pop.
  - Empties all buffers; zeroes lanes and stall_any; rr_ptr unchanged.
  - A push presented in the flush cycle is dropped.
- Reset mid-operation: immediate async clear; buffered results are lost; the ROB re-synchronises via its own reset.
- Pointer widths: buffer pointers are log2(BUF_DEPTH) bits and wrap naturally; count is log2(BUF_DEPTH)+1 bits.

Optional Feature:
- Macro CDB_AGE_PRIORITY_EN.
- When defined:
  - Candidates are ordered by ROB age, age = (rob_idx − rob_head) mod 2^ROB_IDX_W, smallest first.
  - Ties are broken by round-robin order from rr_ptr.
  - rr_ptr still advances as above.
- When undefined: pure round-robin; rob_head is unused.

Decomposition:
- Package cdb_pkg holds:
  - Constants NUM_REQ_DEF, ROB_IDX_W_DEF, DATA_W_DEF.
  - Requester IDs REQ_FXU0=0, REQ_FXU1=1, REQ_LSU=2, REQ_BR=3.
  - Typedef cdb_entry_t {rob_idx, value}.
- Sub-module cdb_result_fifo: one per requester.
  - Depth BUF_DEPTH; ports push/pop/flush, head, count/full/empty.
- Arbiter and lane registers live in cdb_arbiter.

Test Plan:
- Reset/idle: rst pulse mid-cycle, no requests → all outputs 0 immediately; req_ready=4'b1111 after release.
- Single producer: FXU0 pushes idx 3, value 16'h00AA at edge k → after edge k+1, lane0 = {1, 3, 16'h00AA}, lane1 valid=0; next cycle cdb_valid=0.
- Contention: all four push at edge k (idx 1,2,3,4), rr_ptr=0 →
  - After k+1: lanes carry idx 1,2; stall_any=1.
  - After k+2: lanes carry idx 3,4; rr_ptr=0.
- Backpressure: LSU pushes 3 results back-to-back while lanes are saturated by FXU0/FXU1/branch → req_ready[2]=0 after two entries; third held until a pop; LSU results broadcast in push order.
- Flush: 3 results buffered, flush=1 → next cycle cdb_valid=0, all counts 0; the push presented with flush never appears.
- CDB_AGE_PRIORITY_EN: rob_head=14; heads idx 2 (FXU0), 15 (FXU1), 0 (LSU) → lanes carry 15, then 0; idx 2 follows next cycle.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants, requester IDs and the result-entry type for the CDB arbiter slice.
package cdb_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int ROB_IDX_W_DEF = 4;
    localparam int DATA_W_DEF    = 16;

    localparam int REQ_FXU0 = 0;
    localparam int REQ_FXU1 = 1;
    localparam int REQ_LSU  = 2;
    localparam int REQ_BR   = 3;

    typedef struct packed {
        logic [ROB_IDX_W_DEF-1:0] rob_idx;
        logic [DATA_W_DEF-1:0]    value;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-producer result buffer: small circular FIFO holding {rob_idx, value} until the arbiter pops it.
module cdb_result_fifo #(
    parameter int DEPTH  = 2,
    parameter int IDX_W  = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [IDX_W-1:0]  push_rob_idx,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic [IDX_W-1:0]  head_rob_idx,
    output logic [DATA_W-1:0] head_value,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0]  mem_idx_r [DEPTH];
    logic [DATA_W-1:0] mem_val_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; flush beats push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_idx_r[i] <= '0;
                mem_val_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_idx_r[wr_ptr_r] <= push_rob_idx;
                mem_val_r[wr_ptr_r] <= push_value;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_rob_idx = mem_idx_r[rd_ptr_r];
    assign head_value   = mem_val_r[rd_ptr_r];
    assign count        = count_r;
    assign full         = (count_r == CNT_W'(DEPTH));
    assign empty        = (count_r == CNT_W'(0));

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_LANES buffered results per cycle onto registered lanes.
// Define CDB_AGE_PRIORITY_EN to order candidates by ROB age (ties in round-robin order).
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int NUM_LANES = 2,
    parameter int BUF_DEPTH = 2,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [ROB_IDX_W-1:0]           rob_head,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]      req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_LANES-1:0]           cdb_valid,
    output logic [NUM_LANES*ROB_IDX_W-1:0] indices,
    output logic [NUM_LANES*DATA_W-1:0]    new_values,
    output logic                           stall_any
);

    localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int RR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int KEY_W  = ROB_IDX_W + RR_W;
    localparam int RANK_W = $clog2(NUM_REQ + 1);

    logic [ROB_IDX_W-1:0] head_idx_s [NUM_REQ];
    logic [DATA_W-1:0]    head_val_s [NUM_REQ];
    logic [CNT_W-1:0]     count_s    [NUM_REQ];
    logic [NUM_REQ-1:0]   full_s;
    logic [NUM_REQ-1:0]   empty_s;
    logic [NUM_REQ-1:0]   push_s;
    logic [NUM_REQ-1:0]   cand_s;
    logic [NUM_REQ-1:0]   grant_s;

    logic [RR_W-1:0]      dist_s [NUM_REQ];
    logic [KEY_W-1:0]     key_s  [NUM_REQ];
    logic [RANK_W-1:0]    rank_s [NUM_REQ];
    logic [RANK_W-1:0]    num_cand_s;

    logic [RR_W-1:0]      lane_sel_s [NUM_LANES];
    logic [NUM_LANES-1:0] lane_hit_s;
    logic [RR_W-1:0]      last_s;
    logic [RR_W-1:0]      last_dist_s;
    logic [RR_W-1:0]      rr_next_s;
    logic                 any_grant_s;

    logic [RR_W-1:0]      rr_ptr_r;
    logic [NUM_LANES-1:0] valid_r;
    logic [ROB_IDX_W-1:0] idx_r [NUM_LANES];
    logic [DATA_W-1:0]    val_r [NUM_LANES];
    logic                 stall_r;
    logic                 unused_s;

    // Ready comes from the registered count only, so a full buffer stays not-ready while popping.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        assign req_ready[r] = (count_s[r] != CNT_W'(BUF_DEPTH));
        assign push_s[r]    = req_valid[r] & req_ready[r] & ~flush;

        cdb_result_fifo #(
            .DEPTH  (BUF_DEPTH),
            .IDX_W  (ROB_IDX_W),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .push         (push_s[r]),
            .push_rob_idx (req_rob_idx[r*ROB_IDX_W +: ROB_IDX_W]),
            .push_value   (req_value[r*DATA_W +: DATA_W]),
            .pop          (grant_s[r]),
            .head_rob_idx (head_idx_s[r]),
            .head_value   (head_val_s[r]),
            .count        (count_s[r]),
            .full         (full_s[r]),
            .empty        (empty_s[r])
        );
    end

    assign cand_s = ~empty_s;

    // Each candidate's rank is the number of candidates with a smaller sort key; keys are unique
    // because the scan distance from rr_ptr differs per requester. Rank k drives lane k.
    always_comb begin
        num_cand_s = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            dist_s[r] = RR_W'((r + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ);
`ifdef CDB_AGE_PRIORITY_EN
            key_s[r]  = {head_idx_s[r] - rob_head, dist_s[r]};
`else
            key_s[r]  = {{ROB_IDX_W{1'b0}}, dist_s[r]};
`endif
            num_cand_s = num_cand_s + RANK_W'(cand_s[r]);
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            rank_s[r] = '0;
            for (int j = 0; j < NUM_REQ; j++) begin
                rank_s[r] = rank_s[r] + RANK_W'(cand_s[j] && (key_s[j] < key_s[r]));
            end
            grant_s[r] = cand_s[r] && (rank_s[r] < RANK_W'(NUM_LANES));
        end
    end

    // Lane select per rank, and the granted requester furthest along the scan order for rr_ptr.
    always_comb begin
        lane_hit_s  = '0;
        last_s      = '0;
        last_dist_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_sel_s[l] = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                lane_hit_s[l] = lane_hit_s[l] | (grant_s[r] && (rank_s[r] == RANK_W'(l)));
                lane_sel_s[l] = lane_sel_s[l] |
                                ((grant_s[r] && (rank_s[r] == RANK_W'(l))) ? RR_W'(r) : {RR_W{1'b0}});
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            last_s      = (grant_s[r] && (dist_s[r] >= last_dist_s)) ? RR_W'(r) : last_s;
            last_dist_s = (grant_s[r] && (dist_s[r] >= last_dist_s)) ? dist_s[r] : last_dist_s;
        end
        any_grant_s = |grant_s;
        rr_next_s   = RR_W'((int'(last_s) + 1) % NUM_REQ);
    end

    // Lane registers, stall flag and rotating pointer; flush leaves rr_ptr alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= '0;
            stall_r  <= 1'b0;
            rr_ptr_r <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                idx_r[l] <= '0;
                val_r[l] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
            stall_r <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) begin
                idx_r[l] <= '0;
                val_r[l] <= '0;
            end
        end else begin
            valid_r <= lane_hit_s;
            stall_r <= (num_cand_s > RANK_W'(NUM_LANES));
            for (int l = 0; l < NUM_LANES; l++) begin
                idx_r[l] <= lane_hit_s[l] ? head_idx_s[lane_sel_s[l]] : {ROB_IDX_W{1'b0}};
                val_r[l] <= lane_hit_s[l] ? head_val_s[lane_sel_s[l]] : {DATA_W{1'b0}};
            end
            if (any_grant_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign indices[l*ROB_IDX_W +: ROB_IDX_W] = idx_r[l];
        assign new_values[l*DATA_W +: DATA_W]    = val_r[l];
    end

    assign cdb_valid = valid_r;
    assign stall_any = stall_r;

`ifdef CDB_AGE_PRIORITY_EN
    assign unused_s = ^full_s;
`else
    assign unused_s = ^{full_s, rob_head};
`endif

endmodule
